// File: rtl/pw_entry_collector_if.sv
// Keypad-to-verifier bus: debounced key strobes and door state in, collected entry out.
interface pw_entry_collector_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  current_state;
  logic [16:0] pwsin;
  logic [2:0]  digit_count;
  logic        entry_err;
  logic        timeout_pulse;

  modport master (
    output key_valid, key_code, current_state,
    input  pwsin, digit_count, entry_err, timeout_pulse
  );

  modport slave (
    input  key_valid, key_code, current_state,
    output pwsin, digit_count, entry_err, timeout_pulse
  );
endinterface

// File: rtl/pw_entry_collector.sv
// Collects four BCD digits from the keypad into pwsin, with clear/enter keys,
// inactivity timeout and a flush whenever the door-lock state changes.
module pw_entry_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input logic                 clk,
  input logic                 reset_n,
  pw_entry_collector_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, COLLECT, FULL, DONE} state_e;

  localparam logic [3:0]       KEY_CLEAR = 4'hA;
  localparam logic [3:0]       KEY_ENTER = 4'hB;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX  = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [16:0]       pwsin_q, pwsin_d;
  logic [2:0]        digit_count_q, digit_count_d;
  logic              entry_err_q, entry_err_d;
  logic              timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [1:0]        prev_state_q;

  logic is_digit;
  logic flush;
  logic timed_out;

  always_comb begin
    state_d         = state_q;
    pwsin_d         = pwsin_q;
    digit_count_d   = digit_count_q;
    entry_err_d     = 1'b0;
    timeout_pulse_d = 1'b0;
    idle_d          = idle_q;

    is_digit  = (bus.key_code <= 4'd9);
    flush     = (bus.current_state != prev_state_q);
    timed_out = !bus.key_valid && (state_q != EMPTY) && (idle_q == IDLE_LAST);

    // Priority: state-change flush > clear > timeout > enter/digit
    if (flush) begin
      pwsin_d       = '0;
      digit_count_d = '0;
      state_d       = EMPTY;
    end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
      pwsin_d       = '0;
      digit_count_d = '0;
      state_d       = EMPTY;
    end else if (timed_out) begin
      pwsin_d         = '0;
      digit_count_d   = '0;
      state_d         = EMPTY;
      timeout_pulse_d = 1'b1;
    end else if (bus.key_valid) begin
      if (is_digit && (state_q == EMPTY || state_q == COLLECT)) begin
        pwsin_d       = {1'b0, pwsin_q[11:0], bus.key_code};
        digit_count_d = digit_count_q + 3'd1;
        state_d       = (digit_count_q == 3'd3) ? FULL : COLLECT;
      end else if (bus.key_code == KEY_ENTER) begin
        if (state_q == FULL) begin
          pwsin_d[16] = 1'b1;
          state_d     = DONE;
        end else if (state_q == EMPTY || state_q == COLLECT) begin
          pwsin_d       = '0;
          digit_count_d = '0;
          entry_err_d   = 1'b1;
          state_d       = EMPTY;
        end
      end
    end

    // Idle counter only runs while something is held in the buffer
    if (bus.key_valid || state_d == EMPTY) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= EMPTY;
      pwsin_q         <= '0;
      digit_count_q   <= '0;
      entry_err_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
      idle_q          <= '0;
      prev_state_q    <= '0;
    end else begin
      state_q         <= state_d;
      pwsin_q         <= pwsin_d;
      digit_count_q   <= digit_count_d;
      entry_err_q     <= entry_err_d;
      timeout_pulse_q <= timeout_pulse_d;
      idle_q          <= idle_d;
      prev_state_q    <= bus.current_state;
    end
  end

  assign bus.pwsin         = pwsin_q;
  assign bus.digit_count   = digit_count_q;
  assign bus.entry_err     = entry_err_q;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule
